// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX path: frame bit indices,
// default widths, legal oversampling ratios and the 2-of-3 vote.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W_DEF = 6;
  localparam int unsigned FRAME_BITS_DEF = 11;
  localparam int unsigned BIT_CNT_W      = 5;

  localparam logic [BIT_CNT_W-1:0] BIT_START = 5'd0;
  localparam logic [BIT_CNT_W-1:0] BIT_D0    = 5'd1;
  localparam logic [BIT_CNT_W-1:0] BIT_D7    = 5'd8;
  localparam logic [BIT_CNT_W-1:0] BIT_PAR   = 5'd9;
  localparam logic [BIT_CNT_W-1:0] BIT_STOP  = 5'd10;

  localparam int unsigned PRESCALE_X8  = 8;
  localparam int unsigned PRESCALE_X16 = 16;
  localparam int unsigned PRESCALE_X32 = 32;

  // 2-of-3 majority of the mid-bit samples
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // True for the oversampling ratios the RX path is characterised for
  function automatic logic is_legal_prescale(input int unsigned p);
    return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler_if.sv
// Line/control inputs and sample outputs of the RX data sampler.
// master: RX FSM / line side; slave: the sampler.
interface uart_rx_data_sampler_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
);
  logic                  RX_IN;
  logic                  smp_en;
  logic [PRESCALE_W-1:0] Prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  frame_done;

  modport master (
    output RX_IN, smp_en, Prescale,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done
  );

  modport slave (
    input  RX_IN, smp_en, Prescale,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit oversampling edge counter and frame bit counter.
// frame_done pulses for one cycle when the last bit of the frame wraps.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_smp_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_frame_done
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_frame_done;
  logic [PRESCALE_W-1:0] w_edge_last;

  assign w_edge_last = i_prescale - PRESCALE_W'(1);

  // Edge/bit counting; clears whenever the enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt   <= '0;
      r_bit_cnt    <= BIT_START;
      r_frame_done <= 1'b0;
    end else if (!i_smp_en) begin
      r_edge_cnt   <= '0;
      r_bit_cnt    <= BIT_START;
      r_frame_done <= 1'b0;
    end else if (r_edge_cnt == w_edge_last) begin
      r_edge_cnt <= '0;
      if (r_bit_cnt >= BIT_LAST) begin
        r_bit_cnt    <= BIT_START;
        r_frame_done <= 1'b1;
      end else begin
        r_bit_cnt    <= r_bit_cnt + BIT_CNT_W'(1);
        r_frame_done <= 1'b0;
      end
    end else begin
      r_edge_cnt   <= r_edge_cnt + PRESCALE_W'(1);
      r_frame_done <= 1'b0;
    end
  end

  assign o_edge_cnt   = r_edge_cnt;
  assign o_bit_cnt    = r_bit_cnt;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: takes three mid-bit samples of the line, votes
// them and presents sampled_bit with a one-cycle sample_valid strobe that
// is aligned with edge_cnt == Prescale/2 + 1 of the current bit.
// Build option UART_RX_SYNC_EN: adds a 2-flop synchronizer on RX_IN.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  uart_rx_data_sampler_if.slave  bus
);

  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_frame_done;
  logic                  w_line;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_sp0;
  logic [PRESCALE_W-1:0] w_sp1;
  logic [PRESCALE_W-1:0] w_sp2;
  logic [2:0]            w_vote_nxt;
  logic [2:0]            r_vote;
  logic                  r_sampled_bit;
  logic                  r_sample_valid;

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .FRAME_BITS (FRAME_BITS)
  ) u_cnt (
    .clk          (CLK),
    .rst          (RST),
    .i_smp_en     (bus.smp_en),
    .i_prescale   (bus.Prescale),
    .o_edge_cnt   (w_edge_cnt),
    .o_bit_cnt    (w_bit_cnt),
    .o_frame_done (w_frame_done)
  );

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer, idles high like the line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], bus.RX_IN};
  end

  assign w_line = r_sync[1];
`else
  assign w_line = bus.RX_IN;
`endif

  // Sample points H-2, H-1, H around the bit centre
  assign w_half = bus.Prescale >> 1;
  assign w_sp0  = w_half - PRESCALE_W'(2);
  assign w_sp1  = w_half - PRESCALE_W'(1);
  assign w_sp2  = w_half;

  // Vote register contents after this edge (captures only while enabled)
  always_comb begin
    w_vote_nxt = r_vote;
    if (bus.smp_en) begin
      if (w_edge_cnt == w_sp0) w_vote_nxt[0] = w_line;
      if (w_edge_cnt == w_sp1) w_vote_nxt[1] = w_line;
      if (w_edge_cnt == w_sp2) w_vote_nxt[2] = w_line;
    end
  end

  // Vote registers and the strobe; the strobe lands on edge_cnt == H+1
  // and is withheld if the enable drops on the third-capture cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vote         <= 3'b111;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_vote <= w_vote_nxt;
      if (bus.smp_en && (w_edge_cnt == w_sp2)) begin
        r_sampled_bit  <= majority3(w_vote_nxt);
        r_sample_valid <= 1'b1;
      end else begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  assign bus.edge_cnt     = w_edge_cnt;
  assign bus.bit_cnt      = w_bit_cnt;
  assign bus.frame_done   = w_frame_done;
  assign bus.sampled_bit  = r_sampled_bit;
  assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Bench for uart_rx_data_sampler: per-cycle comparison against a frame-level
// arithmetic model plus directed checks of strobe position, data and timing.
module tb_uart_rx_data_sampler;

  localparam int unsigned PW   = 6;
  localparam int unsigned FB   = 11;
  localparam int unsigned MAXC = 8192;
`ifdef UART_RX_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  typedef struct {
    int         cyc;
    logic [5:0] edge_v;
    logic [4:0] bit_v;
    logic       sb;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_data_sampler_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_data_sampler #(.PRESCALE_W(PW), .FRAME_BITS(FB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          reset_cyc = 0;
  int unsigned en_run = 0;
  int unsigned cur_p = 8;
  logic        last_sb = 1'b1;
  logic        raw_h [MAXC];
  strobe_t     strobes[$];
  int          done_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Line value seen by the vote logic in cycle c
  function automatic logic eff(input int c);
    if (c - LAG < reset_cyc) return 1'b1;
    return raw_h[c - LAG];
  endfunction

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  task automatic set_prescale(input int unsigned p);
    cur_p        = p;
    bus.Prescale = PW'(p);
  endtask

  // Check the current cycle against the model, then drive this cycle's inputs
  task automatic run_cycle(input logic rx, input logic en);
    int unsigned h;
    logic [5:0]  e_edge;
    logic [4:0]  e_bit;
    logic        e_valid;
    logic        e_done;
    strobe_t     s;
    h       = cur_p / 2;
    e_edge  = 6'(en_run % cur_p);
    e_bit   = 5'((en_run / cur_p) % FB);
    e_valid = (en_run > 0) && ((en_run % cur_p) == h + 1);
    e_done  = (en_run > 0) && ((en_run % (cur_p * FB)) == 0);
    if (e_valid) last_sb = maj(eff(cyc - 3), eff(cyc - 2), eff(cyc - 1));
    chk($sformatf("edge_cnt@%0d", cyc),     32'(bus.edge_cnt),     32'(e_edge));
    chk($sformatf("bit_cnt@%0d", cyc),      32'(bus.bit_cnt),      32'(e_bit));
    chk($sformatf("sample_valid@%0d", cyc), 32'(bus.sample_valid), 32'(e_valid));
    chk($sformatf("frame_done@%0d", cyc),   32'(bus.frame_done),   32'(e_done));
    chk($sformatf("sampled_bit@%0d", cyc),  32'(bus.sampled_bit),  32'(last_sb));
    if (bus.sample_valid === 1'b1) begin
      s.cyc = cyc; s.edge_v = bus.edge_cnt; s.bit_v = bus.bit_cnt; s.sb = bus.sampled_bit;
      strobes.push_back(s);
    end
    if (bus.frame_done === 1'b1) done_q.push_back(cyc);
    bus.RX_IN   = rx;
    bus.smp_en  = en;
    raw_h[cyc]  = rx;
    en_run      = en ? en_run + 1 : 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One full frame (start, 8 data LSB-first, even parity, stop) with optional glitches
  task automatic run_frame(input int unsigned p, input logic [7:0] data, input int unsigned glitch_den);
    logic [10:0] bits;
    logic        b;
    set_prescale(p);
    bits = {1'b1, ^data, data, 1'b0};
    for (int k = 0; k < int'(p * FB); k++) begin
      b = bits[k / int'(p)];
      if (glitch_den != 0 && $urandom_range(glitch_den - 1) == 0) b = ~b;
      run_cycle(b, 1'b1);
    end
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
  endtask

  // Frame of all-zero line dropped after stop_at enabled cycles
  task automatic run_abort(input int unsigned p, input int unsigned stop_at, input string tag);
    set_prescale(p);
    strobes.delete();
    for (int k = 0; k < int'(stop_at); k++) run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b0);
    chk({tag, "_edge"},  32'(bus.edge_cnt),     32'd0);
    chk({tag, "_bit"},   32'(bus.bit_cnt),      32'd0);
    chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
    run_cycle(1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_edge"},  32'(bus.edge_cnt),     32'd0);
    chk({tag, "_bit"},   32'(bus.bit_cnt),      32'd0);
    chk({tag, "_sb"},    32'(bus.sampled_bit),  32'd1);
    chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
    chk({tag, "_done"},  32'(bus.frame_done),   32'd0);
  endtask

  initial begin
    logic [10:0] exp5a;
    logic [7:0]  rnd_byte;
    int unsigned rp;
    int          start;
    logic        tr_exp;

    bus.RX_IN    = 1'b1;
    bus.smp_en   = 1'b0;
    bus.Prescale = PW'(8);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Prescale 8, line held low: strobes at edge 5, 8 cycles apart
    set_prescale(8);
    strobes.delete();
    for (int k = 0; k < 20; k++) run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b0);
    chk("p8_nstrobe", 32'(strobes.size()), 32'd2);
    if (strobes.size() >= 2) begin
      chk("p8_s0_edge", 32'(strobes[0].edge_v), 32'd5);
      chk("p8_s0_bit",  32'(strobes[0].bit_v),  32'd0);
      chk("p8_s0_sb",   32'(strobes[0].sb),     32'd0);
      chk("p8_s1_bit",  32'(strobes[1].bit_v),  32'd1);
      chk("p8_gap",     32'(strobes[1].cyc - strobes[0].cyc), 32'd8);
    end

    // Prescale 16, byte 0x5A: one strobe per bit at edge 9, single frame_done
    exp5a = 11'b10010110100;
    strobes.delete();
    done_q.delete();
    run_frame(16, 8'h5A, 0);
    chk("x5a_nstrobe", 32'(strobes.size()), 32'd11);
    chk("x5a_ndone",   32'(done_q.size()),  32'd1);
    for (int i = 0; i < 11; i++) begin
      if (strobes.size() > i) begin
        chk($sformatf("x5a_bit%0d_idx", i),  32'(strobes[i].bit_v),  32'(i));
        chk($sformatf("x5a_bit%0d_edge", i), 32'(strobes[i].edge_v), 32'd9);
        chk($sformatf("x5a_bit%0d_val", i),  32'(strobes[i].sb),     32'(exp5a[i]));
      end
    end

    // Glitch filter at Prescale 16: one low sample is outvoted, two are not
    set_prescale(16);
    strobes.delete();
    for (int k = 0; k < 16; k++) run_cycle((k == 7 - LAG) ? 1'b0 : 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0);
    chk("glitch1_n", 32'(strobes.size()), 32'd1);
    if (strobes.size() >= 1) chk("glitch1_sb", 32'(strobes[0].sb), 32'd1);
    strobes.delete();
    for (int k = 0; k < 16; k++)
      run_cycle((k == 7 - LAG || k == 8 - LAG) ? 1'b0 : 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0);
    chk("glitch2_n", 32'(strobes.size()), 32'd1);
    if (strobes.size() >= 1) chk("glitch2_sb", 32'(strobes[0].sb), 32'd0);

    // Prescale 8: 0->1 transition inside bit 3 at edge 1 and at edge 3
    for (int t = 1; t <= 3; t += 2) begin
      tr_exp = (t == 3 && LAG == 2) ? 1'b0 : 1'b1;
      set_prescale(8);
      strobes.delete();
      for (int k = 0; k < 32; k++) run_cycle((k >= 24 + t) ? 1'b1 : 1'b0, 1'b1);
      run_cycle(1'b1, 1'b0);
      chk($sformatf("trans%0d_n", t), 32'(strobes.size()), 32'd4);
      if (strobes.size() >= 4) begin
        chk($sformatf("trans%0d_bit", t), 32'(strobes[3].bit_v), 32'd3);
        chk($sformatf("trans%0d_sb", t),  32'(strobes[3].sb),     32'(tr_exp));
      end
    end

    // Prescale 32: strobe at edge 17, 352 cycles from enable to frame_done
    strobes.delete();
    done_q.delete();
    start = cyc;
    run_frame(32, 8'hC3, 0);
    chk("p32_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() >= 1) chk("p32_len", 32'(done_q[0] - start), 32'd352);
    if (strobes.size() >= 1) chk("p32_edge", 32'(strobes[0].edge_v), 32'd17);

    // Aborts at bit 4: at edge H-1, and on the third-capture cycle
    run_abort(16, 4 * 16 + 7, "abort_h1");
    chk("abort_h1_n", 32'(strobes.size()), 32'd4);
    run_abort(16, 4 * 16 + 8, "abort_h");
    chk("abort_h_n", 32'(strobes.size()), 32'd4);

    // Async reset mid-frame with sampled_bit last voted 0
    set_prescale(16);
    for (int k = 0; k < 50; k++) run_cycle(1'b0, 1'b1);
    bus.smp_en = 1'b0;
    bus.RX_IN  = 1'b1;
    raw_h[cyc] = 1'b1;
    chk("pre_rst_sb", 32'(bus.sampled_bit), 32'd0);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset_cyc = cyc;
    en_run    = 0;
    last_sb   = 1'b1;
    for (int k = 0; k < 4; k++) run_cycle(1'b1, 1'b0);

    // Randomised frames with occasional one-cycle glitches
    for (int f = 0; f < 5; f++) begin
      case ($urandom_range(2))
        0:       rp = 8;
        1:       rp = 16;
        default: rp = 32;
      endcase
      rnd_byte = 8'($urandom);
      run_frame(rp, rnd_byte, 12);
    end

    // Randomised abort points
    for (int a = 0; a < 3; a++) begin
      rp = (a == 1) ? 8 : 16;
      run_abort(rp, $urandom_range(rp * FB - 1, 1), $sformatf("rabort%0d", a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
